sobel_uart_tx: RTL and testbench

Return path of the Sobel pipeline.
- Accepts binarised edge pixels (one byte per valid strobe) from the filter stage.
- Buffers them in an internal FIFO.
- Serialises them onto a UART line, 8N1, LSB first.
- Sits between the Sobel filter output and the board TX pin. It is the transmit counterpart of the byte receiver that feeds the filter.

---
 rtl/sobel_uart_tx.sv | 208 ++++++++++++++++++++
 tb/tb_sobel_uart_tx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sobel_uart_tx.sv
// Sobel return path: buffers filtered pixel bytes in a FIFO and serialises them as UART 8N1, LSB first.
// Define SOBEL_UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module sobel_uart_tx #(
  parameter int BAUD_CNT_END = 5207,
  parameter int FIFO_DEPTH   = 16,
  parameter int ADDR_W       = 4
) (
  input  logic       sclk,
  input  logic       rst_n,
  input  logic       pi_flag,
  input  logic [7:0] pi_data,
  output logic       tx,
  output logic       busy,
  output logic       full,
  output logic       ovf
);

  localparam int BAUD_W = (BAUD_CNT_END > 0) ? $clog2(BAUD_CNT_END + 1) : 1;
  localparam logic [BAUD_W-1:0] BAUD_END = BAUD_W'(BAUD_CNT_END);
  localparam logic [ADDR_W:0]   DEPTH    = (ADDR_W+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef SOBEL_UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } txState_t;

  txState_t state_q, state_d;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] wrPtr_q, rdPtr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, ovf_q;

  logic [BAUD_W-1:0] baudCnt_q, baudCnt_d;
  logic [2:0]        bitCnt_q, bitCnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
`ifdef SOBEL_UART_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  logic       push, pop, baudEnd, fifoEmpty;
  logic [7:0] headData;

  // Full is judged on the pre-edge count, so a pop on the same edge cannot rescue a write.
  assign push      = pi_flag && (count_q != DEPTH);
  assign fifoEmpty = (count_q == '0);
  assign headData  = mem_q[rdPtr_q];
  assign baudEnd   = (baudCnt_q == BAUD_END);

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (push) mem_q[wrPtr_q] <= pi_data;
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + 1'b1;
      if (pop)  rdPtr_q <= rdPtr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == DEPTH);
      if (pi_flag && (count_q == DEPTH)) ovf_q <= 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    baudCnt_d = baudCnt_q;
    bitCnt_d  = bitCnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    pop       = 1'b0;
`ifdef SOBEL_UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    unique case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (!fifoEmpty) begin
          pop       = 1'b1;
          shift_d   = headData;
          baudCnt_d = '0;
          tx_d      = 1'b0;
          busy_d    = 1'b1;
          state_d   = START;
`ifdef SOBEL_UART_TX_PARITY_EN
          parity_d  = ^headData;
`endif
        end
      end
      START: begin
        if (baudEnd) begin
          baudCnt_d = '0;
          tx_d      = shift_q[0];
          bitCnt_d  = '0;
          state_d   = DATA;
        end else begin
          baudCnt_d = baudCnt_q + 1'b1;
        end
      end
      DATA: begin
        if (baudEnd) begin
          baudCnt_d = '0;
          if (bitCnt_q == 3'd7) begin
`ifdef SOBEL_UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end else begin
            shift_d  = {1'b0, shift_q[7:1]};
            tx_d     = shift_q[1];
            bitCnt_d = bitCnt_q + 1'b1;
          end
        end else begin
          baudCnt_d = baudCnt_q + 1'b1;
        end
      end
`ifdef SOBEL_UART_TX_PARITY_EN
      PARITY: begin
        if (baudEnd) begin
          baudCnt_d = '0;
          tx_d      = 1'b1;
          state_d   = STOP;
        end else begin
          baudCnt_d = baudCnt_q + 1'b1;
        end
      end
`endif
      STOP: begin
        if (baudEnd) begin
          baudCnt_d = '0;
          // A queued byte chains straight into the next start bit with no idle gap.
          if (!fifoEmpty) begin
            pop       = 1'b1;
            shift_d   = headData;
            tx_d      = 1'b0;
            state_d   = START;
`ifdef SOBEL_UART_TX_PARITY_EN
            parity_d  = ^headData;
`endif
          end else begin
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end else begin
          baudCnt_d = baudCnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      baudCnt_q <= '0;
      bitCnt_q  <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
`ifdef SOBEL_UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      baudCnt_q <= baudCnt_d;
      bitCnt_q  <= bitCnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
`ifdef SOBEL_UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign full = full_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_sobel_uart_tx.sv
// Directed bench for sobel_uart_tx with 4-clock bits and a 4-entry FIFO.
// Honours SOBEL_UART_TX_PARITY_EN to expect the parity bit in every frame.
module tb_sobel_uart_tx;

  localparam int BIT = 4;
`ifdef SOBEL_UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       sclk;
  logic       rst_n;
  logic       pi_flag;
  logic [7:0] pi_data;
  logic       tx, busy, full, ovf;

  int checks   = 0;
  int failures = 0;

  sobel_uart_tx #(
    .BAUD_CNT_END(3),
    .FIFO_DEPTH  (4),
    .ADDR_W      (2)
  ) dut (
    .sclk   (sclk),
    .rst_n  (rst_n),
    .pi_flag(pi_flag),
    .pi_data(pi_data),
    .tx     (tx),
    .busy   (busy),
    .full   (full),
    .ovf    (ovf)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  // Guards against a stalled run so the bench always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h required %0h", tag, actual, expected);
    end
  endtask

  // Called at a negedge; strobes one byte so the next posedge writes it.
  task automatic applyStimulus(input logic [7:0] data);
    pi_flag = 1'b1;
    pi_data = data;
    @(negedge sclk);
    pi_flag = 1'b0;
  endtask

  // Entered on the first clock of bit firstBit; samples each bit on its second clock
  // and returns on the first clock after the frame.
  task automatic checkFrame(input logic [7:0] data, input int firstBit);
    logic [10:0] bits;
    bits      = '0;
    bits[8:1] = data;
`ifdef SOBEL_UART_TX_PARITY_EN
    bits[9]   = ^data;
    bits[10]  = 1'b1;
`else
    bits[9]   = 1'b1;
`endif
    if (firstBit == 0) begin
      checkOutput($sformatf("startEdgeTx_%02h", data), 32'(tx), 32'd0);
      checkOutput($sformatf("startEdgeBusy_%02h", data), 32'(busy), 32'd1);
    end
    for (int i = firstBit; i < NBITS; i++) begin
      @(negedge sclk);
      checkOutput($sformatf("frame%02h_bit%0d", data, i), 32'(tx), 32'(bits[i]));
      checkOutput($sformatf("frame%02h_busy%0d", data, i), 32'(busy), 32'd1);
      repeat (BIT - 2) @(negedge sclk);
      if (i == NBITS - 1) checkOutput($sformatf("frame%02h_busyTail", data), 32'(busy), 32'd1);
      @(negedge sclk);
    end
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    repeat (2) @(negedge sclk);
    rst_n = 1'b1;
    @(negedge sclk);
  endtask

  initial begin
    logic sawActivity;
    rst_n   = 1'b0;
    pi_flag = 1'b0;
    pi_data = 8'h00;
    repeat (3) @(negedge sclk);
    checkOutput("resetTx",   32'(tx),   32'd1);
    checkOutput("resetBusy", 32'(busy), 32'd0);
    checkOutput("resetFull", 32'(full), 32'd0);
    checkOutput("resetOvf",  32'(ovf),  32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge sclk);

    $display("[TB] single byte 0xA5");
    applyStimulus(8'hA5);
    checkOutput("t1_txBeforePop", 32'(tx), 32'd1);
    checkOutput("t1_busyBeforePop", 32'(busy), 32'd0);
    @(negedge sclk);
    checkFrame(8'hA5, 0);
    checkOutput("t1_busyAfter", 32'(busy), 32'd0);
    checkOutput("t1_txAfter",   32'(tx),   32'd1);
    repeat (5) @(negedge sclk);
    checkOutput("t1_txIdle", 32'(tx), 32'd1);

    $display("[TB] back-to-back 0x00 0xFF");
    pi_flag = 1'b1;
    pi_data = 8'h00;
    @(negedge sclk);
    pi_data = 8'hFF;
    @(negedge sclk);
    pi_flag = 1'b0;
    checkFrame(8'h00, 0);
    checkFrame(8'hFF, 0);
    checkOutput("t2_busyAfter", 32'(busy), 32'd0);
    checkOutput("t2_txAfter",   32'(tx),   32'd1);
    checkOutput("t2_fullAfter", 32'(full), 32'd0);
    repeat (8) @(negedge sclk);
    checkOutput("t2_stillIdle", 32'(busy), 32'd0);

`ifdef SOBEL_UART_TX_PARITY_EN
    $display("[TB] parity frames");
    applyStimulus(8'hA5);
    @(negedge sclk);
    checkFrame(8'hA5, 0);
    checkOutput("t6_busyAfterA5", 32'(busy), 32'd0);
    applyStimulus(8'h07);
    @(negedge sclk);
    checkFrame(8'h07, 0);
    checkOutput("t6_busyAfter07", 32'(busy), 32'd0);
`endif

    $display("[TB] overflow with six strobes");
    for (int i = 0; i < 6; i++) begin
      pi_flag = 1'b1;
      pi_data = 8'(i + 1);
      @(negedge sclk);
      if (i == 1) checkOutput("t3_txStart", 32'(tx), 32'd0);
      if (i == 3) checkOutput("t3_fullAt3", 32'(full), 32'd0);
      if (i == 4) begin
        checkOutput("t3_fullAt4", 32'(full), 32'd1);
        checkOutput("t3_ovfAt4",  32'(ovf),  32'd0);
      end
      if (i == 5) begin
        checkOutput("t3_ovfAt5",  32'(ovf),  32'd1);
        checkOutput("t3_fullAt5", 32'(full), 32'd1);
      end
    end
    pi_flag = 1'b0;
    checkFrame(8'h01, 1);
    checkOutput("t3_fullAfterPop", 32'(full), 32'd0);
    checkFrame(8'h02, 0);
    checkFrame(8'h03, 0);
    checkFrame(8'h04, 0);
    checkFrame(8'h05, 0);
    checkOutput("t3_busyEnd", 32'(busy), 32'd0);
    checkOutput("t3_ovfSticky", 32'(ovf), 32'd1);

    $display("[TB] push refused on pop edge, then reset mid-frame");
    resetDut();
    checkOutput("t4_ovfCleared", 32'(ovf), 32'd0);
    for (int i = 0; i < 5; i++) begin
      pi_flag = 1'b1;
      pi_data = 8'(i + 1);
      @(negedge sclk);
    end
    pi_flag = 1'b0;
    checkOutput("t4_fullSetup", 32'(full), 32'd1);
    repeat (NBITS * BIT - 4) @(negedge sclk);
    checkOutput("t4_fullBeforeEdge", 32'(full), 32'd1);
    checkOutput("t4_ovfBeforeEdge",  32'(ovf),  32'd0);
    checkOutput("t4_txStop",         32'(tx),   32'd1);
    pi_flag = 1'b1;
    pi_data = 8'h99;
    @(negedge sclk);
    pi_flag = 1'b0;
    checkOutput("t4_ovfAfterEdge",  32'(ovf),  32'd1);
    checkOutput("t4_fullAfterEdge", 32'(full), 32'd0);
    checkOutput("t4_txNextStart",   32'(tx),   32'd0);
    checkOutput("t4_busyChained",   32'(busy), 32'd1);

    repeat (17) @(negedge sclk);
    checkOutput("t5_txDataBit3", 32'(tx), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_txAsync",   32'(tx),   32'd1);
    checkOutput("t5_busyAsync", 32'(busy), 32'd0);
    checkOutput("t5_fullAsync", 32'(full), 32'd0);
    checkOutput("t5_ovfAsync",  32'(ovf),  32'd0);
    repeat (2) @(negedge sclk);
    rst_n = 1'b1;
    sawActivity = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge sclk);
      if (tx !== 1'b1 || busy !== 1'b0) sawActivity = 1'b1;
    end
    checkOutput("t5_quietAfterReset", 32'(sawActivity), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
